// File: rtl/decoder_test_sequencer.sv
// Hardware test driver for one Helios decoder byte-stream port: frames host measurement
// bytes, parses the decoder response, times it and emits one result record per test.
// Optional: define SEQ_CORR_CRC_EN to fill the crc field with CRC-16/CCITT-FALSE.
module decoder_test_sequencer #(
    parameter int          MEAS_BYTES     = 12,
    parameter int          CORR_BYTES     = 9,
    parameter logic [7:0]  START_MSG      = 8'hFF,
    parameter logic [7:0]  MEAS_HEADER    = 8'h01,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [7:0]     host_data,
    input  logic           host_valid,
    output logic           host_ready,
    output logic [7:0]     dec_tx_data,
    output logic           dec_tx_valid,
    input  logic           dec_tx_ready,
    input  logic [7:0]     dec_rx_data,
    input  logic           dec_rx_valid,
    output logic           dec_rx_ready,
    output logic [104:0]   res_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           halted
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SEND_START = 4'd1,
        S_SEND_HDR   = 4'd2,
        S_SEND_MEAS  = 4'd3,
        S_WAIT_RESP  = 4'd4,
        S_RECV_HDR   = 4'd5,
        S_RECV_CORR  = 4'd6,
        S_EMIT       = 4'd7,
        S_HALT       = 4'd8
    } state_t;

    localparam logic [15:0] MEAS_LAST    = 16'(MEAS_BYTES - 1);
    localparam logic [15:0] CORR_LAST    = 16'(CORR_BYTES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);

    function automatic logic [15:0] popcount8(input logic [7:0] d);
        logic [15:0] cnt;
        cnt = 16'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {15'd0, d[i]};
        end
        return cnt;
    endfunction

    state_t        state_r;
    logic          start_sent_r;
    logic [15:0]   test_idx_r;
    logic [15:0]   byte_cnt_r;
    logic [15:0]   corr_cnt_r;
    logic [1:0]    rcnt_r;
    logic          timeout_r;
    logic [7:0]    iter_r;
    logic [15:0]   cycles_r;
    logic [31:0]   latency_r;
    logic [15:0]   ones_r;
    logic [15:0]   crc_field_s;

`ifdef SEQ_CORR_CRC_EN
    // MSB-first, non-reflected CRC-16 update with polynomial 0x1021
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0]   crc_r;
    assign crc_field_s = crc_r;
`else
    assign crc_field_s = 16'h0000;
`endif

    assign res_data = {test_idx_r, crc_field_s, ones_r, latency_r, cycles_r, iter_r, timeout_r};
    assign busy     = (state_r != S_IDLE) && (state_r != S_HALT);
    assign halted   = (state_r == S_HALT);

    // Handshake outputs decoded from the registered state; SEND_MEAS is a pure passthrough
    always_comb begin
        host_ready   = 1'b0;
        dec_tx_data  = 8'h00;
        dec_tx_valid = 1'b0;
        dec_rx_ready = 1'b0;
        res_valid    = 1'b0;
        case (state_r)
            S_SEND_START: begin
                dec_tx_valid = 1'b1;
                dec_tx_data  = START_MSG;
            end
            S_SEND_HDR: begin
                dec_tx_valid = 1'b1;
                dec_tx_data  = MEAS_HEADER;
            end
            S_SEND_MEAS: begin
                dec_tx_valid = host_valid;
                dec_tx_data  = host_data;
                host_ready   = dec_tx_ready;
            end
            S_WAIT_RESP, S_RECV_HDR, S_RECV_CORR: begin
                dec_rx_ready = 1'b1;
            end
            S_EMIT: begin
                res_valid = 1'b1;
            end
            default: begin
                host_ready = 1'b0;
            end
        endcase
    end

    // Sequencer state, response parsing and result fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            start_sent_r <= 1'b0;
            test_idx_r   <= 16'd0;
            byte_cnt_r   <= 16'd0;
            corr_cnt_r   <= 16'd0;
            rcnt_r       <= 2'd0;
            timeout_r    <= 1'b0;
            iter_r       <= 8'd0;
            cycles_r     <= 16'd0;
            latency_r    <= 32'd0;
            ones_r       <= 16'd0;
`ifdef SEQ_CORR_CRC_EN
            crc_r        <= 16'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (enable) begin
                        state_r <= start_sent_r ? S_SEND_HDR : S_SEND_START;
                    end
                end
                S_SEND_START: begin
                    if (dec_tx_ready) begin
                        start_sent_r <= 1'b1;
                        state_r      <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    if (dec_tx_ready) begin
                        byte_cnt_r <= 16'd0;
                        state_r    <= S_SEND_MEAS;
                    end
                end
                S_SEND_MEAS: begin
                    if (host_valid && dec_tx_ready) begin
                        byte_cnt_r <= byte_cnt_r + 16'd1;
                        if (byte_cnt_r == MEAS_LAST) begin
                            // Clear every field so a timeout record carries only timeout/latency/idx
                            latency_r <= 32'd0;
                            timeout_r <= 1'b0;
                            iter_r    <= 8'd0;
                            cycles_r  <= 16'd0;
                            ones_r    <= 16'd0;
`ifdef SEQ_CORR_CRC_EN
                            crc_r     <= 16'd0;
`endif
                            state_r   <= S_WAIT_RESP;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (dec_rx_valid) begin
                        iter_r  <= dec_rx_data;
                        rcnt_r  <= 2'd1;
                        state_r <= S_RECV_HDR;
                    end else if (latency_r == TIMEOUT_LAST) begin
                        latency_r <= TIMEOUT_VAL;
                        timeout_r <= 1'b1;
                        state_r   <= S_EMIT;
                    end else if (latency_r != 32'hFFFF_FFFF) begin
                        latency_r <= latency_r + 32'd1;
                    end
                end
                S_RECV_HDR: begin
                    if (dec_rx_valid) begin
                        if (rcnt_r == 2'd1) begin
                            cycles_r[15:8] <= dec_rx_data;
                            rcnt_r         <= 2'd2;
                        end else begin
                            cycles_r[7:0]  <= dec_rx_data;
                            corr_cnt_r     <= 16'd0;
`ifdef SEQ_CORR_CRC_EN
                            crc_r          <= 16'hFFFF;
`endif
                            state_r        <= S_RECV_CORR;
                        end
                    end
                end
                S_RECV_CORR: begin
                    if (dec_rx_valid) begin
                        ones_r     <= ones_r + popcount8(dec_rx_data);
`ifdef SEQ_CORR_CRC_EN
                        crc_r      <= crc16_ccitt_byte(crc_r, dec_rx_data);
`endif
                        corr_cnt_r <= corr_cnt_r + 16'd1;
                        if (corr_cnt_r == CORR_LAST) begin
                            state_r <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        test_idx_r <= test_idx_r + 16'd1;
                        if (timeout_r) begin
                            state_r <= S_HALT;
                        end else if (enable) begin
                            state_r <= S_SEND_HDR;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_test_sequencer.sv
// Directed bench for decoder_test_sequencer: a table of whole test cases plus
// hand-written timeout, halt and mid-test reset sequences.
module tb_decoder_test_sequencer;

    localparam int MEAS = 12;
    localparam int CORR = 9;
    localparam int TO   = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    host_data;
    logic          host_valid;
    logic          host_ready;
    logic [7:0]    dec_tx_data;
    logic          dec_tx_valid;
    logic          dec_tx_ready;
    logic [7:0]    dec_rx_data;
    logic          dec_rx_valid;
    logic          dec_rx_ready;
    logic [104:0]  res_data;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          halted;

    decoder_test_sequencer #(
        .MEAS_BYTES(MEAS), .CORR_BYTES(CORR), .START_MSG(8'hFF),
        .MEAS_HEADER(8'h01), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .dec_tx_data(dec_tx_data), .dec_tx_valid(dec_tx_valid), .dec_tx_ready(dec_tx_ready),
        .dec_rx_data(dec_rx_data), .dec_rx_valid(dec_rx_valid), .dec_rx_ready(dec_rx_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   base;
        int           delay;
        logic [7:0]   iter;
        logic [15:0]  cyc;
        logic [71:0]  corr;
        bit           start;
        int           hold;
        bit           stall;
        bit           crc_known;
        logic [15:0]  crc_val;
        logic [31:0]  lat;
        logic [15:0]  ones;
        logic [15:0]  idx;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    bit         stall_mode = 1'b0;
    logic [7:0] tx_q[$];
    int         host_cnt = 0;
    int         res_seen = 0;
    vec_t       vecs[5];

    // Transfers are committed at the following posedge; sample mid-cycle
    always @(negedge clk) begin
        if (dec_tx_valid && dec_tx_ready) tx_q.push_back(dec_tx_data);
        if (host_valid && host_ready) host_cnt++;
        if (res_valid) res_seen++;
    end

    initial begin
        dec_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            dec_tx_ready = stall_mode ? ~dec_tx_ready : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [71:0] bytes);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < CORR; k++) begin
            b = bytes[71 - 8*k -: 8];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic vec_t mk(input logic [7:0] base, input int delay, input logic [7:0] iter,
                                input logic [15:0] cyc, input logic [71:0] corr, input bit start,
                                input int hold, input bit stall, input bit crc_known,
                                input logic [15:0] crc_val, input logic [31:0] lat,
                                input logic [15:0] ones, input logic [15:0] idx);
        vec_t v;
        v.base = base; v.delay = delay; v.iter = iter; v.cyc = cyc; v.corr = corr;
        v.start = start; v.hold = hold; v.stall = stall; v.crc_known = crc_known;
        v.crc_val = crc_val; v.lat = lat; v.ones = ones; v.idx = idx;
        return v;
    endfunction

    task automatic send_meas(input logic [7:0] base);
        int i = 0;
        int g = 0;
        host_data  = base;
        host_valid = 1'b1;
        while (i < MEAS && g < 300) begin
            @(negedge clk);
            g++;
            if (host_ready) i++;
            @(posedge clk); #1;
            host_data  = base + 8'(i);
            host_valid = (i < MEAS);
        end
        host_valid = 1'b0;
        check("meas_sent", 128'(i), 128'(MEAS));
    endtask

    task automatic rx_send(input logic [7:0] b);
        int g = 0;
        bit done = 1'b0;
        dec_rx_data  = b;
        dec_rx_valid = 1'b1;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
            if (dec_rx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        check("rx_accept", 128'(done), 128'(1));
    endtask

    task automatic wait_record(input int limit, output bit found);
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          tx0 = tx_q.size();
        int          h0 = host_cnt;
        bit          found;
        bit          ok;
        bit          stable;
        int          n;
        logic [7:0]  exp_tx[$];
        logic [15:0] crc_e;
        logic [104:0] exp_rec;
        stall_mode = v.stall;
        send_meas(v.base);
        repeat (v.delay) begin @(posedge clk); #1; end
        rx_send(v.iter);
        rx_send(v.cyc[15:8]);
        rx_send(v.cyc[7:0]);
        for (int k = 0; k < CORR; k++) rx_send(v.corr[71 - 8*k -: 8]);
        dec_rx_valid = 1'b0;
        stall_mode   = 1'b0;
        wait_record(40, found);
        check("rec_valid", 128'(found), 128'(1));
`ifdef SEQ_CORR_CRC_EN
        crc_e = v.crc_known ? v.crc_val : crc_ref(v.corr);
`else
        crc_e = 16'h0000;
`endif
        exp_rec = {v.idx, crc_e, v.ones, v.lat, v.cyc, v.iter, 1'b0};
        check("record", 128'(res_data), 128'(exp_rec));
        if (v.start) exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'h01);
        for (int i = 0; i < MEAS; i++) exp_tx.push_back(v.base + 8'(i));
        n  = tx_q.size() - tx0;
        ok = (n == exp_tx.size());
        for (int i = 0; i < exp_tx.size() && ok; i++) if (tx_q[tx0 + i] !== exp_tx[i]) ok = 1'b0;
        check("tx_seq_len", 128'(n), 128'(exp_tx.size()));
        check("tx_seq_ok", 128'(ok), 128'(1));
        check("host_cnt", 128'(host_cnt - h0), 128'(MEAS));
        if (v.hold > 0) begin
            stable = 1'b1;
            repeat (v.hold) begin
                @(negedge clk);
                if (!res_valid || res_data !== exp_rec || dec_tx_valid) stable = 1'b0;
            end
            check("rec_hold_stable", 128'(stable), 128'(1));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        bit          found;
        int          rs0;
        int          tx0;
        logic [71:0] s9;
        s9 = "123456789";
        vecs[0] = mk(8'h00, 10, 8'h03, 16'h012C, {9{8'hFF}}, 1'b1, 0, 1'b0, 1'b0, 16'h0000, 32'd10, 16'd72, 16'd0);
        vecs[1] = mk(8'h10, 0,  8'h07, 16'h1234, s9,         1'b0, 5, 1'b0, 1'b1, 16'h29B1, 32'd0,  16'd33, 16'd1);
        vecs[2] = mk(8'hA0, 49, 8'hFF, 16'hFFFF, {9{8'h00}}, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 32'd49, 16'd0,  16'd2);
        vecs[3] = mk(8'h55, 3,  8'h01, 16'h0001, 72'h80_01_03_07_0F_1F_3F_7F_FF,
                                                              1'b0, 0, 1'b1, 1'b0, 16'h0000, 32'd3,  16'd37, 16'd3);
        vecs[4] = mk(8'h20, 5,  8'h02, 16'h0100, {9{8'h01}}, 1'b1, 0, 1'b0, 1'b0, 16'h0000, 32'd5,  16'd9,  16'd0);

        reset = 1'b1; enable = 1'b0; host_data = 8'h00; host_valid = 1'b0;
        dec_rx_data = 8'h00; dec_rx_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 128'({dec_tx_valid, host_ready, dec_rx_ready, res_valid, busy, halted}), 128'(0));
        check("reset_res_data", 128'(res_data), 128'(0));

        enable = 1'b1;
        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // Silent decoder: timeout record, then sticky halt
        tx0 = tx_q.size();
        send_meas(8'h40);
        wait_record(TO + 20, found);
        check("to_rec_valid", 128'(found), 128'(1));
        check("to_record", 128'(res_data), 128'({16'd4, 16'd0, 16'd0, 32'(TO), 16'd0, 8'd0, 1'b1}));
        check("to_tx_first", 128'(tx_q[tx0]), 128'(8'h01));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready    = 1'b0;
        host_valid   = 1'b1;
        dec_rx_valid = 1'b1;
        dec_rx_data  = 8'h5A;
        @(negedge clk);
        check("halt_ctrl", 128'({halted, busy, dec_rx_ready, dec_tx_valid, host_ready, res_valid}), 128'(6'b100000));
        repeat (4) @(negedge clk);
        check("halt_sticky", 128'({halted, dec_rx_ready, res_valid}), 128'(3'b100));
        @(posedge clk); #1;
        reset = 1'b1; enable = 1'b0; host_valid = 1'b0; dec_rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("halt_cleared", 128'({halted, busy, res_data}), 128'(0));

        // Reset in the middle of the correction bytes: no record, full restart
        enable = 1'b1;
        send_meas(8'h60);
        rx_send(8'h05); rx_send(8'h00); rx_send(8'h10);
        rx_send(8'hAA); rx_send(8'h55); rx_send(8'hF0);
        dec_rx_valid = 1'b0;
        rs0 = res_seen;
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_no_rec", 128'(res_seen - rs0), 128'(0));
        check("midreset_idle", 128'({busy, dec_tx_valid, dec_rx_ready}), 128'(0));
        enable = 1'b1;
        run_vec(vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_test_sequencer.md
Name:
decoder_test_sequencer

Overview:
Synthesizable test driver for one Helios decoder byte-stream port. It lets multi-FPGA test runs execute on hardware without a simulator.
- Frames host-supplied measurement bytes into decoder input messages.
- Parses the decoder response: iteration byte, 16-bit cycle count, correction bytes.
- Measures wall-clock latency and enforces a timeout.
- Emits one fixed-format result record per test case.

It sits between a host byte FIFO and the decoder input/output FIFOs.

Parameters:
MEAS_BYTES, 12, measurement bytes per test (BYTES_PER_ROUND * rounds * contexts); must be >= 1
CORR_BYTES, 9, correction bytes per response; must be >= 1
START_MSG, 8'hFF, start-decoding command byte
MEAS_HEADER, 8'h01, measurement-data header byte
TIMEOUT_CYCLES, 100000, maximum WAIT_RESP cycles before abort; must be >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; sequencer leaves IDLE when high
host_data  in  8  measurement byte from host
host_valid  in  1  host byte valid
host_ready  out  1  host byte accepted
dec_tx_data  out  8  byte to decoder input FIFO
dec_tx_valid  out  1  decoder input valid
dec_tx_ready  in  1  decoder input ready
dec_rx_data  in  8  byte from decoder output FIFO
dec_rx_valid  in  1  decoder output valid
dec_rx_ready  out  1  decoder output accept
res_data  out  105  result record
res_valid  out  1  record valid
res_ready  in  1  record accepted
busy  out  1  state != IDLE and != HALT
halted  out  1  timeout occurred; sticky until reset

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Handshakes: every transfer occurs on valid & ready in the same cycle. Valid never depends on ready.
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - test_idx = 0, start_sent = 0, all counters 0.
- Reset mid-operation: abandons the current test. No record is emitted. START_MSG is resent after the next enable.
- States and transitions:
  - IDLE: on enable, go to SEND_START if !start_sent, else SEND_HDR.
  - SEND_START: dec_tx_valid=1, data=START_MSG. On accept, set start_sent=1 and go to SEND_HDR.
  - SEND_HDR: dec_tx_valid=1, data=MEAS_HEADER. On accept, go to SEND_MEAS with byte_cnt=0.
  - SEND_MEAS: combinational passthrough (dec_tx_data=host_data, dec_tx_valid=host_valid, host_ready=dec_tx_ready). byte_cnt increments per transfer. The transfer at byte_cnt==MEAS_BYTES-1 goes to WAIT_RESP. host_ready=0 in all other states.
  - WAIT_RESP: latency counter is cleared on entry and increments every cycle, saturating at 32'hFFFFFFFF. dec_rx_ready=1.
    - First accepted byte is the iteration count; go to RECV_HDR with rcnt=1. Latency freezes on that cycle; the count excludes the acceptance cycle.
    - If timer reaches TIMEOUT_CYCLES with no byte, set timeout flag and go to EMIT.
    - A byte arriving in the same cycle as the timeout wins: no timeout.
  - RECV_HDR: dec_rx_ready=1. Byte rcnt=1 gives cycles[15:8]; rcnt=2 gives cycles[7:0], then go to RECV_CORR with ccnt=0.
  - RECV_CORR: dec_rx_ready=1. Each byte adds its popcount to corr_ones (16-bit, wraps). After CORR_BYTES bytes go to EMIT.
  - EMIT: res_valid=1 and the record is held stable.
    - On accept, test_idx increments (wraps at 16'hFFFF→0).
    - Next state: HALT if timeout, else SEND_HDR if enable, else IDLE.
    - No new test starts until the record is accepted.
  - HALT: halted=1. All ready/valid outputs are 0 until reset. Prevents late response bytes from misframing.
- Record layout, LSB first:
  - [0] timeout
  - [8:1] iterations
  - [24:9] dec_cycles
  - [56:25] latency
  - [72:57] corr_ones
  - [88:73] crc
  - [104:89] test_idx
- Timeout record: all fields except timeout, latency (=TIMEOUT_CYCLES) and test_idx are 0.
- enable deasserted mid-test: the current test completes; the block returns to IDLE after EMIT.

Optional Feature:
SEQ_CORR_CRC_EN:
- Defined: crc field holds CRC-16/CCITT-FALSE over all correction bytes, in order.
  - Poly 0x1021, init 0xFFFF, MSB-first, no reflect, no xorout.
  - CRC is initialised on entry to RECV_CORR and updated one byte per accepted transfer.
- Undefined: crc field is constant 0 and no CRC logic is synthesized.

Test Plan:
1. Reset, enable=1, MEAS_BYTES=12, host supplies 0x00..0x0B, decoder always ready → dec_tx sequence is FF,01,00..0B; host_ready low outside SEND_MEAS.
2. Decoder responds 10 cycles after last meas byte with 03,01,2C then 9 bytes of 0xFF → record timeout=0, iterations=3, dec_cycles=300, latency=10, corr_ones=72, test_idx=0.
3. With SEQ_CORR_CRC_EN, correction bytes ASCII "123456789" → crc=0x29B1; without the macro → crc=0.
4. Second test back-to-back with enable held → START_MSG not resent (dec_tx begins 01), record test_idx=1. Hold res_ready=0 for 5 cycles → record stable and no new header sent.
5. TIMEOUT_CYCLES=50, decoder silent → record timeout=1, latency=50; then halted=1 and dec_rx_ready=0 even if dec_rx_valid rises; reset clears halted.
6. Assert reset during RECV_CORR → no record emitted; after enable, dec_tx restarts with FF,01 and test_idx=0.
